// File: rtl/fft_pkg.sv
// Shared types and constants for the ADC-to-FFT framing path.
package fft_pkg;

    localparam int FFT_LEN  = 256;
    localparam int SAMPLE_W = 16;

    // AXI-S tdata layout: real part low, imaginary part high
    localparam int RE_LSB = 0;
    localparam int RE_W   = 16;
    localparam int IM_LSB = 16;
    localparam int IM_W   = 16;

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} feeder_state_t;

    // Offset-binary ADC code to two's complement: subtracting mid-scale flips the MSB
    // and the borrow sign-extends into the upper bits.
    function automatic logic [SAMPLE_W-1:0] offset_to_signed(input logic [SAMPLE_W-1:0] code,
                                                             input int width);
        logic [SAMPLE_W-1:0] bias;
        bias = '0;
        bias[width-1] = 1'b1;
        return code - bias;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Show-ahead synchronous FIFO: dout is the head entry whenever empty=0; registered full/empty.
// A write while full is accepted only when a read happens in the same cycle.
module sync_fifo_fwft #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      next_count;
    logic             do_wr;
    logic             do_rd;

    assign do_rd = rd_en & ~empty;
    assign do_wr = wr_en & (~full | do_rd);
    assign dout  = mem[rd_ptr];

    always_comb begin
        next_count = count;
        case ({do_wr, do_rd})
            2'b10:   next_count = count + (AW+1)'(1);
            2'b01:   next_count = count - (AW+1)'(1);
            default: next_count = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            count <= next_count;
            empty <= (next_count == '0);
            full  <= (next_count == (AW+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/adc_fft_feeder.sv
// Frames ADC samples into FFT_LEN-beat AXI-S frames; sample_en to m_tvalid is 2 cycles, m_tready stalls are
// absorbed by a skid FIFO (overflow drops samples, flagged per frame). AUTO_TRIG_EN adds the periodic trigger.
module adc_fft_feeder #(
    parameter int FFT_LEN      = fft_pkg::FFT_LEN,
    parameter int DATA_W       = 10,
    parameter int FIFO_DEPTH   = 16,
    parameter int FRAME_PERIOD = 25000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_en,
    input  logic [DATA_W-1:0] ad_data,
    input  logic              ad_otr,
    input  logic              start,
    output logic [31:0]       m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_otr,
    output logic              frame_ovf
);
    import fft_pkg::*;

    localparam int CW = $clog2(FFT_LEN) + 1;

    feeder_state_t       state;
    logic                pending;
    logic                trig;
    logic                smp_vld;
    logic                smp_otr;
    logic [SAMPLE_W-1:0] smp_dat;
    logic [CW-1:0]       push_cnt;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_rd;
    logic [SAMPLE_W:0]   fifo_din;
    logic [SAMPLE_W:0]   fifo_dout;
    logic                wr_req;
    logic                wr_ok;
    logic                drop;
    logic                last_push;
    logic                last_acc;

`ifdef AUTO_TRIG_EN
    localparam int TW = $clog2(FRAME_PERIOD);
    logic [TW-1:0] timer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                timer <= '0;
        else if (timer == TW'(FRAME_PERIOD-1))  timer <= '0;
        else                                    timer <= timer + TW'(1);
    end

    assign trig = start | (timer == TW'(FRAME_PERIOD-1));
`else
    localparam int unused_frame_period = FRAME_PERIOD;
    assign trig = start;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp_vld <= 1'b0;
            smp_otr <= 1'b0;
            smp_dat <= '0;
        end else begin
            smp_vld <= sample_en && (state == CAPTURE);
            smp_otr <= ad_otr;
            smp_dat <= offset_to_signed(SAMPLE_W'(ad_data), DATA_W);
        end
    end

    assign fifo_rd   = m_tready & ~fifo_empty;
    assign wr_req    = smp_vld && (state == CAPTURE);
    assign wr_ok     = wr_req & (~fifo_full | fifo_rd);
    assign drop      = wr_req & ~wr_ok;
    assign last_push = (push_cnt == CW'(FFT_LEN-1));
    assign fifo_din  = {last_push, smp_dat};
    assign last_acc  = fifo_rd & fifo_dout[SAMPLE_W];

    sync_fifo_fwft #(
        .WIDTH (SAMPLE_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_ok),
        .din   (fifo_din),
        .full  (fifo_full),
        .rd_en (fifo_rd),
        .dout  (fifo_dout),
        .empty (fifo_empty)
    );

    // Gate with valid so stale RAM contents never reach the bus after reset.
    always_comb begin
        m_tdata                    = '0;
        m_tdata[IM_LSB +: IM_W]    = '0;
        if (!fifo_empty) m_tdata[RE_LSB +: RE_W] = fifo_dout[SAMPLE_W-1:0];
    end
    assign m_tvalid = ~fifo_empty;
    assign m_tlast  = ~fifo_empty & fifo_dout[SAMPLE_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pending    <= 1'b0;
            push_cnt   <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_otr  <= 1'b0;
            frame_ovf  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            pending    <= pending | trig;
            case (state)
                IDLE: begin
                    if (pending) begin
                        state     <= CAPTURE;
                        pending   <= trig;
                        push_cnt  <= '0;
                        frame_otr <= 1'b0;
                        frame_ovf <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (wr_ok) begin
                        push_cnt  <= push_cnt + CW'(1);
                        frame_otr <= frame_otr | smp_otr;
                        if (last_push) state <= DRAIN;
                    end
                    if (drop) frame_ovf <= 1'b1;
                end
                DRAIN: begin
                    if (last_acc) begin
                        frame_done <= 1'b1;
                        if (pending) begin
                            state     <= CAPTURE;
                            pending   <= trig;
                            push_cnt  <= '0;
                            frame_otr <= 1'b0;
                            frame_ovf <= 1'b0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_fft_feeder.sv
// Directed bench for adc_fft_feeder with a beat scoreboard and an AXI-S stability monitor.
module tb_adc_fft_feeder;
    localparam int FFT_LEN      = 256;
    localparam int DATA_W       = 10;
    localparam int FIFO_DEPTH   = 16;
    localparam int FRAME_PERIOD = 1000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sample_en = 1'b0;
    logic [DATA_W-1:0] ad_data = '0;
    logic              ad_otr = 1'b0;
    logic              start = 1'b0;
    logic              m_tready = 1'b1;
    logic [31:0]       m_tdata;
    logic              m_tvalid;
    logic              m_tlast;
    logic              busy;
    logic              frame_done;
    logic              frame_otr;
    logic              frame_ovf;

    always #10 clk = ~clk;

    adc_fft_feeder #(
        .FFT_LEN      (FFT_LEN),
        .DATA_W       (DATA_W),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .FRAME_PERIOD (FRAME_PERIOD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sample_en  (sample_en),
        .ad_data    (ad_data),
        .ad_otr     (ad_otr),
        .start      (start),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_otr  (frame_otr),
        .frame_ovf  (frame_ovf)
    );

    int                 n_assert = 0;
    int                 n_fail = 0;
    logic [32:0]        sb [$];
    int                 mode = 0;          // 0 scoreboard, 1 increasing ramp, 2 all-zero data
    int                 cyc = 0;
    int                 done_cnt = 0;
    int                 frame_beats = 0;
    int                 last_frame_len = 0;
    int                 last_tl_cyc = -1;
    int                 done_cyc = -1;
    logic               done_busy = 1'b0;
    int                 done_times [$];
    logic               stall_prev = 1'b0;
    logic [31:0]        prev_dat = '0;
    logic               prev_last = 1'b0;
    logic signed [15:0] prev_re = 16'sh8000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        while (!busy && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input int base, input int bound, input string tag);
        int n = 0;
        while (done_cnt == base && n < bound) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(tag, 32'(done_cnt - base), 32'd1);
    endtask

    // pat 0: ramp code i; pat 1: mid-scale with over-range on sample 100
    task automatic send_frame(input int spacing, input int pat, input int start_idx, input int stop_beats);
        int v;
        logic [32:0] e;
        for (int i = 0; i < FFT_LEN; i++) begin
            if (stop_beats > 0 && frame_beats >= stop_beats) break;
            @(posedge clk); #1;
            v = (pat == 1) ? 512 : i;
            sample_en = 1'b1;
            ad_data   = DATA_W'(v);
            ad_otr    = (pat == 1) && (i == 99);
            start     = (start_idx >= 0) && (i == start_idx || i == start_idx + 2);
            e = {(i == FFT_LEN-1), 16'h0000, 16'(v - 512)};
            sb.push_back(e);
            @(posedge clk); #1;
            sample_en = 1'b0;
            ad_otr    = 1'b0;
            start     = 1'b0;
            repeat (spacing - 2) @(posedge clk);
        end
    endtask

    initial begin
        int base;
        int base2;

        fork
            begin
                logic [32:0] e;
                forever begin
                    @(negedge clk);
                    cyc++;
                    if (rst) begin
                        sb.delete();
                        frame_beats = 0;
                        stall_prev  = 1'b0;
                        prev_re     = 16'sh8000;
                    end else begin
                        if (frame_done) begin
                            done_cnt++;
                            done_cyc  = cyc;
                            done_busy = busy;
                            done_times.push_back(cyc);
                        end
                        if (stall_prev) begin
                            chk("hold_vld", 32'(m_tvalid), 32'd1);
                            chk("hold_dat", m_tdata, prev_dat);
                            chk("hold_last", 32'(m_tlast), 32'(prev_last));
                        end
                        if (m_tvalid && m_tready) begin
                            frame_beats++;
                            chk("tlast_pos", 32'(m_tlast), 32'(frame_beats == FFT_LEN));
                            if (mode == 0) begin
                                chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
                                if (sb.size() > 0) begin
                                    e = sb.pop_front();
                                    chk("beat_dat", m_tdata, e[31:0]);
                                    chk("beat_last", 32'(m_tlast), 32'(e[32]));
                                end
                            end else if (mode == 1) begin
                                chk("ramp_incr", 32'($signed(m_tdata[15:0]) > prev_re), 32'd1);
                                chk("imag_zero", 32'(m_tdata[31:16]), 32'd0);
                                prev_re = m_tdata[15:0];
                            end else begin
                                chk("zero_dat", m_tdata, 32'd0);
                            end
                            if (m_tlast) begin
                                last_frame_len = frame_beats;
                                frame_beats    = 0;
                                last_tl_cyc    = cyc;
                                prev_re        = 16'sh8000;
                            end
                        end
                        stall_prev = m_tvalid && !m_tready;
                        prev_dat   = m_tdata;
                        prev_last  = m_tlast;
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_tlast", 32'(m_tlast), 32'd0);
        chk("rst_tdata", m_tdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_otr", 32'(frame_otr), 32'd0);
        chk("rst_ovf", 32'(frame_ovf), 32'd0);
        rst = 1'b0;

`ifdef AUTO_TRIG_EN
        mode      = 2;
        ad_data   = 10'd512;
        sample_en = 1'b1;
        repeat (3500) @(posedge clk);
        #1 sample_en = 1'b0;
        chk("auto_count", 32'(done_times.size() >= 3), 32'd1);
        if (done_times.size() >= 3) begin
            chk("auto_gap1", 32'(done_times[1] - done_times[0]), 32'(FRAME_PERIOD));
            chk("auto_gap2", 32'(done_times[2] - done_times[1]), 32'(FRAME_PERIOD));
        end
`else
        // Ramp frame, no stalls
        base = done_cnt;
        pulse_start();
        wait_busy("t1_busy");
        send_frame(4, 0, -1, 0);
        wait_done(base, 100, "t1_done");
        chk("t1_len", 32'(last_frame_len), 32'(FFT_LEN));
        chk("t1_otr", 32'(frame_otr), 32'd0);
        chk("t1_ovf", 32'(frame_ovf), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        chk("t1_single_done", 32'(done_cnt - base), 32'd1);
        chk("t1_idle_busy", 32'(busy), 32'd0);
        chk("t1_sb_drained", 32'(sb.size()), 32'd0);

        // Mid-scale frame with one over-range sample
        base = done_cnt;
        pulse_start();
        wait_busy("t2_busy");
        send_frame(4, 1, -1, 0);
        wait_done(base, 100, "t2_done");
        chk("t2_len", 32'(last_frame_len), 32'(FFT_LEN));
        chk("t2_otr", 32'(frame_otr), 32'd1);
        chk("t2_ovf", 32'(frame_ovf), 32'd0);

        // Continuous sampling with a 40-cycle stall: drops but still a full frame
        base = done_cnt;
        mode = 1;
        pulse_start();
        wait_busy("t3_busy");
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            sample_en = 1'b1;
            ad_data   = DATA_W'(i);
            m_tready  = !(i >= 100 && i < 140);
        end
        @(posedge clk); #1;
        sample_en = 1'b0;
        m_tready  = 1'b1;
        wait_done(base, 200, "t3_done");
        chk("t3_len", 32'(last_frame_len), 32'(FFT_LEN));
        chk("t3_ovf", 32'(frame_ovf), 32'd1);
        chk("t3_otr", 32'(frame_otr), 32'd0);
        mode = 0;

        // Two starts during capture merge into exactly one follow-on frame
        base = done_cnt;
        pulse_start();
        wait_busy("t4_busy");
        send_frame(5, 0, 10, 0);
        wait_done(base, 100, "t4_done1");
        base2 = done_cnt;
        chk("t4_gap", 32'(done_cyc - last_tl_cyc), 32'd1);
        chk("t4_busy_boundary", 32'(done_busy), 32'd1);
        chk("t4_busy_after", 32'(busy), 32'd1);
        send_frame(4, 0, -1, 0);
        wait_done(base2, 100, "t4_done2");
        chk("t4_len2", 32'(last_frame_len), 32'(FFT_LEN));
        repeat (300) @(posedge clk);
        #1;
        chk("t4_no_third", 32'(done_cnt - base), 32'd2);
        chk("t4_idle_busy", 32'(busy), 32'd0);

        // No trigger source: nothing starts on its own
        base = done_cnt;
        repeat (5000) @(posedge clk);
        #1;
        chk("t5_no_frames", 32'(done_cnt - base), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_tvalid", 32'(m_tvalid), 32'd0);

        // Asynchronous reset mid-frame, then a clean frame
        base = done_cnt;
        pulse_start();
        wait_busy("t6_busy");
        send_frame(4, 0, -1, 50);
        #3 rst = 1'b1;
        #1;
        chk("t6_rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_tlast", 32'(m_tlast), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        chk("t6_no_done", 32'(done_cnt - base), 32'd0);
        chk("t6_sb_flushed", 32'(sb.size()), 32'd0);
        base = done_cnt;
        pulse_start();
        wait_busy("t6_busy2");
        send_frame(4, 0, -1, 0);
        wait_done(base, 100, "t6_done");
        chk("t6_len", 32'(last_frame_len), 32'(FFT_LEN));
        chk("t6_ovf", 32'(frame_ovf), 32'd0);
        chk("t6_sb_drained", 32'(sb.size()), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
